// File: rtl/stdp_pkg.sv
// stdp_pkg: shared types and limits for the STDP learning scheduler.
package stdp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRIVE, S_SAMPLE, S_LEARN, S_DONE} state_e;
    localparam int W_WIDTH = 8;
    localparam int AGE_W = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;
    localparam logic [W_WIDTH-1:0] W_MAX = 8'd255;
endpackage

// File: rtl/stdp_sat_addsub.sv
// stdp_sat_addsub: 8-bit saturating adder/subtractor (op_i=1 subtracts), result clamped to 0..255.
module stdp_sat_addsub
    import stdp_pkg::*;
(
    input  logic               op_i,
    input  logic [W_WIDTH-1:0] a_i,
    input  logic [W_WIDTH-1:0] b_i,
    output logic [W_WIDTH-1:0] y_o
);
    logic [W_WIDTH:0] sum;
    // Bit 8 flags carry on add and borrow on subtract.
    assign sum = op_i ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
    assign y_o = sum[W_WIDTH] ? (op_i ? '0 : W_MAX) : sum[W_WIDTH-1:0];
endmodule

// File: rtl/stdp_sched.sv
// stdp_sched: time-step scheduler sharing one saturating adder between current accumulation and STDP learning.
// Define STDP_SCHED_LTD_EN to add depression (LTD) and the post-spike age tracker.
module stdp_sched
    import stdp_pkg::*;
#(
    parameter int N_SYN   = 4,
    parameter int W_INIT  = 32,
    parameter int A_PLUS  = 4,
    parameter int A_MINUS = 3,
    parameter int WINDOW  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step_i,
    input  logic [N_SYN-1:0]         pre_i,
    input  logic                     learn_en_i,
    input  logic                     post_spike_i,
    output logic [W_WIDTH-1:0]       current_o,
    output logic                     neuron_en_o,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic [$clog2(N_SYN)-1:0] wsel_i,
    output logic [W_WIDTH-1:0]       wdata_o
);
    localparam int IW = $clog2(N_SYN);
    localparam logic [IW-1:0] LAST = IW'(N_SYN - 1);
    localparam logic [AGE_W-1:0] WIN = AGE_W'(WINDOW);

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic [N_SYN-1:0]     pre_q;
    logic                 learn_q, post_q;
    logic [W_WIDTH-1:0]   acc_q, current_q;
    logic                 neuron_en_q, busy_q, done_q;
    logic [W_WIDTH-1:0]   w_q [N_SYN];
    logic [AGE_W-1:0]     pre_age_q [N_SYN];
`ifdef STDP_SCHED_LTD_EN
    logic [AGE_W-1:0]     post_age_q;
`endif
    logic                 ltp, ltd, op;
    logic [W_WIDTH-1:0]   a, b, y;

    always_comb begin
        ltp = post_q && (pre_q[idx_q] || pre_age_q[idx_q] < WIN);
`ifdef STDP_SCHED_LTD_EN
        ltd = !ltp && pre_q[idx_q] && post_age_q < WIN;
`else
        ltd = 1'b0;
`endif
        op = state_q == S_LEARN && ltd;
        a = state_q == S_LEARN ? w_q[idx_q] : acc_q;
        b = state_q == S_LEARN ? (ltp ? W_WIDTH'(A_PLUS) : ltd ? W_WIDTH'(A_MINUS) : '0)
                               : (pre_q[idx_q] ? w_q[idx_q] : '0);
    end

    stdp_sat_addsub u_alu (.op_i(op), .a_i(a), .b_i(b), .y_o(y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pre_q       <= '0;
            learn_q     <= 1'b0;
            post_q      <= 1'b0;
            acc_q       <= '0;
            current_q   <= '0;
            neuron_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i]       <= W_WIDTH'(W_INIT);
                pre_age_q[i] <= AGE_MAX;
            end
`ifdef STDP_SCHED_LTD_EN
            post_age_q  <= AGE_MAX;
`endif
        end else begin
            neuron_en_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: if (step_i) begin
                    state_q <= S_ACCUM;
                    pre_q   <= pre_i;
                    learn_q <= learn_en_i;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
                // Last sum goes straight to current_o so neuron_en_o is high during DRIVE.
                S_ACCUM: begin
                    acc_q <= y;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q     <= S_DRIVE;
                        idx_q       <= '0;
                        current_q   <= y;
                        neuron_en_q <= 1'b1;
                    end
                end
                S_DRIVE: state_q <= S_SAMPLE;
                S_SAMPLE: begin
                    post_q  <= post_spike_i;
                    state_q <= S_LEARN;
                end
                S_LEARN: begin
                    if (learn_q) w_q[idx_q] <= y;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q <= S_DONE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    for (int i = 0; i < N_SYN; i++)
                        pre_age_q[i] <= pre_q[i] ? '0 :
                                        pre_age_q[i] == AGE_MAX ? AGE_MAX : pre_age_q[i] + 1'b1;
`ifdef STDP_SCHED_LTD_EN
                    post_age_q <= post_q ? '0 :
                                  post_age_q == AGE_MAX ? AGE_MAX : post_age_q + 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign current_o   = current_q;
    assign neuron_en_o = neuron_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wdata_o     = int'(wsel_i) < N_SYN ? w_q[wsel_i] : '0;
endmodule

// File: tb/tb_stdp_sched.sv
// tb_stdp_sched: directed checks of stdp_sched step timing, accumulation, STDP window, saturation and reset.
module tb_stdp_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_i = 1'b0;
    logic [3:0] pre_i = '0;
    logic       learn_en_i = 1'b0;
    logic       post_spike_i = 1'b0;
    logic [7:0] current_o;
    logic       neuron_en_o, busy_o, done_o;
    logic [1:0] wsel_i = '0;
    logic [7:0] wdata_o;

    int errors = 0;
    int checks = 0;
    int lat, en_c;
    logic [7:0] cur;

    stdp_sched dut (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .pre_i(pre_i), .learn_en_i(learn_en_i),
        .post_spike_i(post_spike_i), .current_o(current_o), .neuron_en_o(neuron_en_o),
        .busy_o(busy_o), .done_o(done_o), .wsel_i(wsel_i), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; step_i = 1'b0; pre_i = '0; learn_en_i = 1'b0; post_spike_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_step(input logic [3:0] pre, input logic learn, input logic post,
                           output int l, output int e, output logic [7:0] c_out);
        @(negedge clk);
        pre_i = pre; learn_en_i = learn; post_spike_i = post; step_i = 1'b1;
        l = 0; e = 0; c_out = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            step_i = 1'b0;
            if (neuron_en_o) begin e = c; c_out = current_o; end
            if (done_o) begin l = c; break; end
        end
        if (l == 0) begin
            errors++; checks++;
            $display("FAIL step_timeout: done_o not seen within 30 cycles, need 11");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (current_o !== 8'd0) begin errors++; $display("FAIL reset_current: got %0d need 0", current_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy_o); end
        checks++; if ({neuron_en_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b need 00", {neuron_en_o, done_o}); end
        for (int i = 0; i < 4; i++) begin
            wsel_i = 2'(i); #1;
            checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL reset_w%0d: got %0d need 32", i, wdata_o); end
        end
    endtask

    task automatic test_ltp_single();
        do_reset();
        do_step(4'b0001, 1'b1, 1'b1, lat, en_c, cur);
        checks++; if (lat !== 11) begin errors++; $display("FAIL ltp_done_cycle: got %0d need 11", lat); end
        checks++; if (en_c !== 5) begin errors++; $display("FAIL ltp_drive_cycle: got %0d need 5", en_c); end
        checks++; if (cur !== 8'd32) begin errors++; $display("FAIL ltp_current: got %0d need 32", cur); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ltp_busy_in_done: got %b need 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            wsel_i = 2'(i); #1;
            checks++; if (wdata_o !== (i == 0 ? 8'd36 : 8'd32)) begin errors++; $display("FAIL ltp_w%0d: got %0d need %0d", i, wdata_o, i == 0 ? 36 : 32); end
        end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ltp_busy_after: got %b need 0", busy_o); end
    endtask

    task automatic test_no_post();
        do_reset();
        do_step(4'b1111, 1'b1, 1'b0, lat, en_c, cur);
        checks++; if (cur !== 8'd128) begin errors++; $display("FAIL nopost_current: got %0d need 128", cur); end
        checks++; if (current_o !== 8'd128) begin errors++; $display("FAIL nopost_hold: got %0d need 128", current_o); end
        for (int i = 0; i < 4; i++) begin
            wsel_i = 2'(i); #1;
            checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL nopost_w%0d: got %0d need 32", i, wdata_o); end
        end
    endtask

    task automatic test_window();
        do_reset();
        do_step(4'b0100, 1'b1, 1'b0, lat, en_c, cur);
        repeat (3) do_step(4'b0000, 1'b1, 1'b0, lat, en_c, cur);
        do_step(4'b0000, 1'b1, 1'b1, lat, en_c, cur);
        checks++; if (cur !== 8'd0) begin errors++; $display("FAIL window_current: got %0d need 0", cur); end
        wsel_i = 2'd2; #1;
        checks++; if (wdata_o !== 8'd36) begin errors++; $display("FAIL window_in_w2: got %0d need 36", wdata_o); end
        wsel_i = 2'd0; #1;
        checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL window_in_w0: got %0d need 32", wdata_o); end
        do_reset();
        do_step(4'b0100, 1'b1, 1'b0, lat, en_c, cur);
        repeat (4) do_step(4'b0000, 1'b1, 1'b0, lat, en_c, cur);
        do_step(4'b0000, 1'b1, 1'b1, lat, en_c, cur);
        wsel_i = 2'd2; #1;
        checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL window_out_w2: got %0d need 32", wdata_o); end
    endtask

    task automatic test_ltd();
        logic [7:0] exp_w1;
`ifdef STDP_SCHED_LTD_EN
        exp_w1 = 8'd29;
`else
        exp_w1 = 8'd32;
`endif
        do_reset();
        do_step(4'b0000, 1'b1, 1'b1, lat, en_c, cur);
        do_step(4'b0010, 1'b1, 1'b0, lat, en_c, cur);
        checks++; if (cur !== 8'd32) begin errors++; $display("FAIL ltd_current: got %0d need 32", cur); end
        wsel_i = 2'd1; #1;
        checks++; if (wdata_o !== exp_w1) begin errors++; $display("FAIL ltd_w1: got %0d need %0d", wdata_o, exp_w1); end
        wsel_i = 2'd0; #1;
        checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL ltd_w0: got %0d need 32", wdata_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        do_step(4'b1111, 1'b1, 1'b1, lat, en_c, cur);
        do_step(4'b1111, 1'b1, 1'b1, lat, en_c, cur);
        checks++; if (cur !== 8'd144) begin errors++; $display("FAIL sat_second_current: got %0d need 144", cur); end
        repeat (55) do_step(4'b1111, 1'b1, 1'b1, lat, en_c, cur);
        checks++; if (cur !== 8'd255) begin errors++; $display("FAIL sat_current: got %0d need 255", cur); end
        for (int i = 0; i < 4; i++) begin
            wsel_i = 2'(i); #1;
            checks++; if (wdata_o !== 8'd255) begin errors++; $display("FAIL sat_w%0d: got %0d need 255", i, wdata_o); end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        do_step(4'b1111, 1'b0, 1'b1, lat, en_c, cur);
        for (int i = 0; i < 4; i++) begin
            wsel_i = 2'(i); #1;
            checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL freeze_w%0d: got %0d need 32", i, wdata_o); end
        end
        do_step(4'b1111, 1'b1, 1'b1, lat, en_c, cur);
        wsel_i = 2'd3; #1;
        checks++; if (wdata_o !== 8'd36) begin errors++; $display("FAIL relearn_w3: got %0d need 36", wdata_o); end
    endtask

    task automatic test_back_to_back();
        int l;
        do_reset();
        @(negedge clk);
        pre_i = 4'b0001; learn_en_i = 1'b1; post_spike_i = 1'b0; step_i = 1'b1;
        l = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            step_i = (c == 3);
            if (c == 3) pre_i = 4'b1111;
            if (c == 1) begin
                checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy_start: got %b need 1", busy_o); end
            end
            if (done_o) begin l = c; break; end
        end
        checks++; if (l !== 11) begin errors++; $display("FAIL b2b_done_cycle: got %0d need 11", l); end
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_step_in_done: busy got %b need 0", busy_o); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_stays: busy got %b need 0", busy_o); end
        checks++; if (current_o !== 8'd32) begin errors++; $display("FAIL b2b_current: got %0d need 32", current_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        pre_i = 4'b1111; learn_en_i = 1'b1; post_spike_i = 1'b1; step_i = 1'b1;
        repeat (8) begin @(negedge clk); step_i = 1'b0; end
        wsel_i = 2'd0; #1;
        checks++; if (wdata_o !== 8'd36) begin errors++; $display("FAIL mid_w0_learned: got %0d need 36", wdata_o); end
        rst_n = 1'b0; #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b need 0", busy_o); end
        checks++; if (current_o !== 8'd0) begin errors++; $display("FAIL mid_current: got %0d need 0", current_o); end
        checks++; if (wdata_o !== 8'd32) begin errors++; $display("FAIL mid_w0: got %0d need 32", wdata_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL mid_after: got %b need 00", {busy_o, done_o}); end
    endtask

    initial begin
        test_reset();
        test_ltp_single();
        test_no_post();
        test_window();
        test_ltd();
        test_saturation();
        test_freeze();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stdp_sched.md
# stdp_sched

Learning scheduler that sequences the shared STDP/LIF neuron datapath over discrete time steps. Holds one 8-bit synaptic weight per presynaptic input and, per step, sums the active weights into the neuron's 8-bit current input. It then samples the neuron's spike and applies pair-based STDP (potentiation, optionally depression) to each weight. One saturating adder/subtractor is time-shared between accumulation and learning, one synapse per cycle.

## Interface
Parameters:
- N_SYN, 4: number of synapses (2..8)
- W_INIT, 32: weight value after reset
- A_PLUS, 4: LTP increment
- A_MINUS, 3: LTD decrement
- WINDOW, 4: STDP window in steps (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- step_i  in  1  start one time step (accepted in IDLE only)
- pre_i  in  N_SYN  presynaptic spikes, latched when step accepted
- learn_en_i  in  1  weight updates enabled (latched with step)
- post_spike_i  in  1  neuron spike, sampled in SAMPLE
- current_o  out  8  current drive to neuron, registered
- neuron_en_o  out  1  one-cycle pulse: current_o newly valid
- busy_o  out  1  step in progress
- done_o  out  1  one-cycle pulse: step complete
- wsel_i  in  $clog2(N_SYN)  weight readback select
- wdata_o  out  8  weight[wsel_i], combinational read

## Operation
- FSM: IDLE -> ACCUM (N_SYN cycles) -> DRIVE -> SAMPLE -> LEARN (N_SYN cycles) -> DONE -> IDLE.
- IDLE: on step_i, latch pre_i and learn_en_i, clear accumulator, index=0.
- ACCUM: acc = sat255(acc + (pre[idx] ? w[idx] : 0)), idx increments.
- DRIVE: current_o <= acc, neuron_en_o=1. current_o holds until next DRIVE.
- SAMPLE: latch post = post_spike_i.
- LEARN, per idx, only if learn latched:
  - LTP: post && (pre[idx] || pre_age[idx] < WINDOW) -> w = min(w+A_PLUS, 255).
  - LTD: else if pre[idx] && post_age < WINDOW -> w = max(w-A_MINUS, 0).
  - Simultaneous pre and post in the same step: LTP only.
- DONE: done_o=1. Ages update: pre_age[i] = pre[i] ? 0 : sat15(pre_age[i]+1); post_age likewise. Ages update even when learning is disabled.
- Age semantics: 0 = spiked in the previous step; 15 = never or stale.
- step_i outside IDLE is ignored (no queueing).
- Reset values: weights = W_INIT; ages = 15; current_o = 0; neuron_en_o, busy_o, done_o = 0; state = IDLE.
- Reset mid-step aborts the step and restores all reset values.

## Timing
- step_i high in IDLE at cycle t: ACCUM t+1..t+N_SYN; DRIVE t+N_SYN+1; SAMPLE t+N_SYN+2; LEARN t+N_SYN+3..t+2N_SYN+2; DONE t+2N_SYN+3. Default is 11 cycles.
- busy_o is high from t+1 through DONE inclusive. The earliest next step is accepted the cycle after DONE.
- post_spike_i must reflect the neuron's response to the current driven at DRIVE. The neuron output registers one cycle after neuron_en_o.
- The weight write in LEARN is visible on wdata_o the following cycle.

## Configuration
- STDP_SCHED_LTD_EN defined: LTD rule active as above.
- Not defined: no LTD branch, and post_age is not implemented. Weights only increase or hold. A_MINUS is ignored.

## Structure
- Package stdp_pkg: state enum, W_WIDTH=8, AGE_W=4, AGE_MAX=15, W_MAX=255.
- Sub-module stdp_sat_addsub: 8-bit saturating add/sub (op, a, b -> y, clamped 0..255). One instance, shared by ACCUM and LEARN.

## Test plan
- Reset; pre_i=0001, step, post_spike_i=1 in SAMPLE -> current_o=32, w0=36, w1..w3=32, done_o at t+11.
- Reset; pre_i=1111, step, post=0 -> current_o=128, weights unchanged (no post, all ages 15).
- Pre on syn2 at step k, post at step k+4 -> w2=36. Repeat from reset with post at k+5 -> w2=32 (age 4, outside window).
- With LTD_EN: post-only step, then pre_i=0010 with post=0 next step -> w1=29. Without LTD_EN -> w1=32.
- Drive weights to 255 via repeated LTP, pre_i=1111 -> current_o=255, weights stay at 255. learn_en_i=0 step -> weights frozen.
- step_i pulsed while busy_o is high -> ignored. rst_n low mid-LEARN -> weights 32, busy_o=0, current_o=0 immediately.
